ft601_device_model: RTL and testbench
=====================================

Name: ft601_device_model

Overview:
- Synthesizable model of the FT601 chip side of the 245 synchronous FIFO bus, clocked by the FTDI clock.
- Used for on-board loopback and simulation against the FPGA-side FT245 receiver and transmitter logic.
- RX buffer: host-loaded words presented to the FPGA master.
- TX buffer: words written by the FPGA master, drained by a host-side read port.
- Flags FT245 protocol violations made by the master.

Parameters:
BW, 32, data bus width in bits
LGFLEN, 4, log2 depth of each buffer (depth = 16)

Ports:
i_ftdi_clk  in  1  FTDI bus clock; all logic on rising edge
i_reset  in  1  synchronous active-high reset
i_ftdi_oe_n  in  1  master output-enable request, active low
i_ftdi_rd_n  in  1  master read strobe, active low
i_ftdi_wr_n  in  1  master write strobe, active low
o_ftdi_rxf_n  out  1  low = RX data available to master
o_ftdi_txe_n  out  1  low = TX space available to master
io_ftdi_data  inout  BW  shared data bus
io_ftdi_be  inout  4  byte enables
i_rx_hold  in  1  forces rxf_n high; emulates host pause
i_tx_hold  in  1  forces txe_n high; emulates host busy
i_host_wr  in  1  push i_host_data into RX buffer
i_host_data  in  BW  host word destined for FPGA
o_host_full  out  1  RX buffer full
i_host_rd  in  1  pop TX buffer head
o_host_data  out  BW  TX buffer head word
o_host_empty  out  1  TX buffer empty
o_rx_level  out  LGFLEN+1  RX buffer occupancy
o_tx_level  out  LGFLEN+1  TX buffer occupancy
o_protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (i_reset high at a clock edge): both buffers empty, o_rx_level=0, o_tx_level=0, o_ftdi_rxf_n=1, o_ftdi_txe_n=1, o_protocol_err=0, o_host_empty=1, o_host_full=0, bus tri-stated.
- Reset mid-transfer discards buffer contents; takes priority over all other events that cycle.
- Bus drive (combinational):
  - When i_ftdi_oe_n=0 and i_ftdi_wr_n=1: io_ftdi_data = RX head word (0 if RX empty), io_ftdi_be = 4'b1111.
  - Otherwise both are Z.
- Master read pop: occurs at an edge where rd_n=0, oe_n=0, wr_n=1 and o_ftdi_rxf_n=0.
  - Master samples the head word at that same edge; the next word is presented the following cycle.
  - rd_n=0 while rxf_n=1: no pop, not an error.
- Master write capture: occurs at an edge where wr_n=0, rd_n=1, oe_n=1 and o_ftdi_txe_n=0.
  - io_ftdi_data is pushed into the TX buffer; io_ftdi_be is ignored (full words only).
  - wr_n=0 while txe_n=1: no push, not an error.
- Protocol errors set o_protocol_err, which stays set until reset:
  - rd_n=0 with oe_n=1;
  - rd_n=0 and wr_n=0 together;
  - wr_n=0 with oe_n=0.
  - In each of these cases neither a pop nor a push occurs, and the device does not drive the bus.
- Flags are registered and computed from next-state occupancy:
  - o_ftdi_rxf_n <= (rx_next==0) | i_rx_hold
  - o_ftdi_txe_n <= (tx_next==DEPTH) | i_tx_hold
  - Consequence: popping the last word at edge N gives rxf_n=1 from cycle N+1; the master never sees a stale low.
  - First cycle after reset release: txe_n goes 0 at the next edge.
- Host ports:
  - i_host_wr while o_host_full=1: ignored, even if a master pop occurs the same cycle.
  - i_host_rd while o_host_empty=1: ignored.
  - o_host_data is the registered TX head, valid while o_host_empty=0.
- Simultaneous push and pop on one buffer: both take effect, level unchanged.
- Pointers are LGFLEN+1 bits and wrap modulo 2*DEPTH; level = wr_ptr - rd_ptr, truncated to LGFLEN+1 bits.
- Full/empty derive from pointer compare.
- No state machine is needed beyond the buffer and error logic; the master drives sequencing.

Test Plan:
- Reset then idle -> rxf_n=1 and txe_n=0 one cycle after release; levels 0; bus Z; err=0.
- Host pushes 0x1..0x5; master holds oe_n=0 then asserts rd_n=0 for 5 cycles -> master samples 1,2,3,4,5 in order; rxf_n=1 the cycle after the 5th pop; o_rx_level=0.
- Master writes 0xA0..0xAF with oe_n=1 and wr_n=0 -> 16 words accepted; txe_n=1 after the 16th; a 17th write is ignored; host read returns 0xA0..0xAF.
- i_rx_hold=1 with 3 RX words while the master asserts rd_n -> no pops, rx_level stays 3; release hold -> rxf_n=0 next cycle and reads resume at word 0.
- Master asserts rd_n=0 with oe_n=1 -> o_protocol_err=1 and stays 1; level unchanged; bus not driven; cleared only by i_reset.
- TX full while the host pops and the master writes in the same cycle -> write accepted (txe_n was 0 only if level<16); with level 15, simultaneous push and pop keeps level 15.

Source files
------------

// File: rtl/ft601_device_model.sv
// rtl/ft601_device_model.sv - FT601 chip-side model of the 245 synchronous FIFO bus
// Host-loaded RX buffer feeds the FPGA master; master writes fill a host-drained TX buffer.
module ft601_device_model #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4
) (
    input  logic              i_ftdi_clk,
    input  logic              i_reset,
    input  logic              i_ftdi_oe_n,
    input  logic              i_ftdi_rd_n,
    input  logic              i_ftdi_wr_n,
    output logic              o_ftdi_rxf_n,
    output logic              o_ftdi_txe_n,
    inout  wire  [BW-1:0]     io_ftdi_data,
    inout  wire  [3:0]        io_ftdi_be,
    input  logic              i_rx_hold,
    input  logic              i_tx_hold,
    input  logic              i_host_wr,
    input  logic [BW-1:0]     i_host_data,
    output logic              o_host_full,
    input  logic              i_host_rd,
    output logic [BW-1:0]     o_host_data,
    output logic              o_host_empty,
    output logic [LGFLEN:0]   o_rx_level,
    output logic [LGFLEN:0]   o_tx_level,
    output logic              o_protocol_err
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_L = (LGFLEN+1)'(DEPTH);

    logic [BW-1:0]   rx_mem_q [DEPTH];
    logic [BW-1:0]   tx_mem_q [DEPTH];
    logic [LGFLEN:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [LGFLEN:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic            rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, err_q, err_d;

    logic            rx_full, rx_empty, tx_full, tx_empty;
    logic            rx_push, rx_pop, tx_push, tx_pop;
    logic            bus_drive, proto_err;
    logic [BW-1:0]   rx_head;
    logic [LGFLEN:0] rx_next_level, tx_next_level;

    always_comb begin
        rx_empty  = (rx_wr_q == rx_rd_q);
        rx_full   = (rx_wr_q[LGFLEN] != rx_rd_q[LGFLEN]) &&
                    (rx_wr_q[LGFLEN-1:0] == rx_rd_q[LGFLEN-1:0]);
        tx_empty  = (tx_wr_q == tx_rd_q);
        tx_full   = (tx_wr_q[LGFLEN] != tx_rd_q[LGFLEN]) &&
                    (tx_wr_q[LGFLEN-1:0] == tx_rd_q[LGFLEN-1:0]);

        // Illegal strobe combinations never move data and never drive the bus.
        proto_err = (!i_ftdi_rd_n && i_ftdi_oe_n) ||
                    (!i_ftdi_rd_n && !i_ftdi_wr_n) ||
                    (!i_ftdi_wr_n && !i_ftdi_oe_n);
        bus_drive = !i_ftdi_oe_n && i_ftdi_wr_n;
        rx_head   = rx_empty ? '0 : rx_mem_q[rx_rd_q[LGFLEN-1:0]];

        rx_pop    = !i_ftdi_rd_n && !i_ftdi_oe_n && i_ftdi_wr_n && !rxf_n_q;
        tx_push   = !i_ftdi_wr_n && i_ftdi_rd_n && i_ftdi_oe_n && !txe_n_q;
        rx_push   = i_host_wr && !rx_full;
        tx_pop    = i_host_rd && !tx_empty;

        rx_wr_d   = rx_wr_q + (LGFLEN+1)'(rx_push);
        rx_rd_d   = rx_rd_q + (LGFLEN+1)'(rx_pop);
        tx_wr_d   = tx_wr_q + (LGFLEN+1)'(tx_push);
        tx_rd_d   = tx_rd_q + (LGFLEN+1)'(tx_pop);

        // Flags look ahead one cycle so the master never acts on a stale level.
        rx_next_level = rx_wr_d - rx_rd_d;
        tx_next_level = tx_wr_d - tx_rd_d;
        rxf_n_d   = (rx_next_level == '0) || i_rx_hold;
        txe_n_d   = (tx_next_level == DEPTH_L) || i_tx_hold;
        err_d     = err_q || proto_err;
    end

    always_ff @(posedge i_ftdi_clk) begin
        if (i_reset) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rxf_n_q <= 1'b1;
            txe_n_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            rxf_n_q <= rxf_n_d;
            txe_n_q <= txe_n_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_ftdi_clk) begin
        if (!i_reset && rx_push)
            rx_mem_q[rx_wr_q[LGFLEN-1:0]] <= i_host_data;
        if (!i_reset && tx_push)
            tx_mem_q[tx_wr_q[LGFLEN-1:0]] <= io_ftdi_data;
    end

    assign io_ftdi_data   = bus_drive ? rx_head : {BW{1'bz}};
    assign io_ftdi_be     = bus_drive ? 4'b1111 : 4'bzzzz;

    assign o_ftdi_rxf_n   = rxf_n_q;
    assign o_ftdi_txe_n   = txe_n_q;
    assign o_protocol_err = err_q;
    assign o_host_full    = rx_full;
    assign o_host_empty   = tx_empty;
    assign o_host_data    = tx_mem_q[tx_rd_q[LGFLEN-1:0]];
    assign o_rx_level     = rx_wr_q - rx_rd_q;
    assign o_tx_level     = tx_wr_q - tx_rd_q;

endmodule

// File: tb/tb_ft601_device_model.sv
// tb/tb_ft601_device_model.sv - directed self-checking bench for ft601_device_model
module tb_ft601_device_model;

    logic        clk = 1'b0;
    logic        rst, oe_n, rd_n, wr_n, rx_hold, tx_hold;
    logic        host_wr, host_rd, tb_drive;
    logic [31:0] host_wdata, tb_data;
    logic        rxf_n, txe_n, host_full, host_empty, perr;
    logic [31:0] host_rdata;
    logic [4:0]  rx_level, tx_level;
    tri1  [31:0] ftdi_data;
    tri1  [3:0]  ftdi_be;
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] UNDRIVEN = 32'hFFFF_FFFF;

    assign ftdi_data = tb_drive ? tb_data : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    ft601_device_model dut (
        .i_ftdi_clk(clk), .i_reset(rst), .i_ftdi_oe_n(oe_n), .i_ftdi_rd_n(rd_n),
        .i_ftdi_wr_n(wr_n), .o_ftdi_rxf_n(rxf_n), .o_ftdi_txe_n(txe_n),
        .io_ftdi_data(ftdi_data), .io_ftdi_be(ftdi_be), .i_rx_hold(rx_hold),
        .i_tx_hold(tx_hold), .i_host_wr(host_wr), .i_host_data(host_wdata),
        .o_host_full(host_full), .i_host_rd(host_rd), .o_host_data(host_rdata),
        .o_host_empty(host_empty), .o_rx_level(rx_level), .o_tx_level(tx_level),
        .o_protocol_err(perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [31:0] d);
        host_wr = 1'b1; host_wdata = d;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        checks++; if (rxf_n !== 1'b1) begin failures++; $display("FAIL rst_rxf got=%b exp=1", rxf_n); end
        checks++; if (txe_n !== 1'b1) begin failures++; $display("FAIL rst_txe got=%b exp=1", txe_n); end
        checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin failures++; $display("FAIL rst_levels got=%0d/%0d exp=0/0", rx_level, tx_level); end
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", perr); end
        checks++; if (host_empty !== 1'b1 || host_full !== 1'b0) begin failures++; $display("FAIL rst_host_flags got=%b%b exp=10", host_empty, host_full); end
        checks++; if (ftdi_data !== UNDRIVEN) begin failures++; $display("FAIL rst_bus got=%h exp=undriven", ftdi_data); end
        rst = 1'b0; tick();
        checks++; if (txe_n !== 1'b0 || rxf_n !== 1'b1) begin failures++; $display("FAIL release_flags got=txe%b rxf%b exp=txe0 rxf1", txe_n, rxf_n); end
    endtask

    task automatic test_master_read();
        for (int k = 1; k <= 5; k++) host_push(32'(k));
        checks++; if (rx_level !== 5'd5 || rxf_n !== 1'b0) begin failures++; $display("FAIL rd_loaded got=lvl%0d rxf%b exp=lvl5 rxf0", rx_level, rxf_n); end
        oe_n = 1'b0; #1;
        checks++; if (ftdi_data !== 32'd1 || ftdi_be !== 4'hf) begin failures++; $display("FAIL rd_oe_head got=%h be=%h exp=1 be=f", ftdi_data, ftdi_be); end
        tick();
        rd_n = 1'b0; #1;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (ftdi_data !== 32'(k)) begin failures++; $display("FAIL rd_word%0d got=%h exp=%h", k, ftdi_data, k); end
            tick();
        end
        checks++; if (rxf_n !== 1'b1 || rx_level !== 5'd0) begin failures++; $display("FAIL rd_drained got=rxf%b lvl%0d exp=rxf1 lvl0", rxf_n, rx_level); end
        checks++; if (ftdi_data !== 32'd0) begin failures++; $display("FAIL rd_empty_bus got=%h exp=0", ftdi_data); end
        rd_n = 1'b1; oe_n = 1'b1; #1;
        checks++; if (ftdi_data !== UNDRIVEN) begin failures++; $display("FAIL rd_release_bus got=%h exp=undriven", ftdi_data); end
    endtask

    task automatic test_master_write();
        wr_n = 1'b0; tb_drive = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tb_data = 32'hA0 + 32'(k);
            tick();
        end
        checks++; if (tx_level !== 5'd16 || txe_n !== 1'b1) begin failures++; $display("FAIL wr_full got=lvl%0d txe%b exp=lvl16 txe1", tx_level, txe_n); end
        tb_data = 32'hFF; tick();
        checks++; if (tx_level !== 5'd16) begin failures++; $display("FAIL wr_17th got=%0d exp=16", tx_level); end
        wr_n = 1'b1; tb_drive = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++; if (host_rdata !== 32'hA0 + 32'(k) || host_empty !== 1'b0) begin failures++; $display("FAIL wr_host_word%0d got=%h exp=%h", k, host_rdata, 32'hA0 + 32'(k)); end
            host_rd = 1'b1; tick();
        end
        host_rd = 1'b0;
        checks++; if (host_empty !== 1'b1 || tx_level !== 5'd0 || txe_n !== 1'b0) begin failures++; $display("FAIL wr_drained got=e%b lvl%0d txe%b exp=e1 lvl0 txe0", host_empty, tx_level, txe_n); end
    endtask

    task automatic test_rx_hold();
        rx_hold = 1'b1;
        host_push(32'h11); host_push(32'h22); host_push(32'h33);
        oe_n = 1'b0; rd_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (rx_level !== 5'd3 || rxf_n !== 1'b1 || perr !== 1'b0) begin failures++; $display("FAIL hold_nopop got=lvl%0d rxf%b err%b exp=lvl3 rxf1 err0", rx_level, rxf_n, perr); end
        rd_n = 1'b1; rx_hold = 1'b0; tick();
        checks++; if (rxf_n !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", rxf_n); end
        rd_n = 1'b0; #1;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (ftdi_data !== 32'h11 * 32'(k)) begin failures++; $display("FAIL hold_word%0d got=%h exp=%h", k, ftdi_data, 32'h11 * 32'(k)); end
            tick();
        end
        checks++; if (rx_level !== 5'd0 || rxf_n !== 1'b1) begin failures++; $display("FAIL hold_drained got=lvl%0d rxf%b exp=lvl0 rxf1", rx_level, rxf_n); end
        rd_n = 1'b1; oe_n = 1'b1;
    endtask

    task automatic test_protocol_err();
        host_push(32'h55);
        rd_n = 1'b0; #1;
        checks++; if (ftdi_data !== UNDRIVEN) begin failures++; $display("FAIL perr_rd_bus got=%h exp=undriven", ftdi_data); end
        tick();
        checks++; if (perr !== 1'b1 || rx_level !== 5'd1) begin failures++; $display("FAIL perr_rd got=err%b lvl%0d exp=err1 lvl1", perr, rx_level); end
        rd_n = 1'b1; tick(); tick();
        checks++; if (perr !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", perr); end
        rst = 1'b1; tick();
        checks++; if (perr !== 1'b0 || rx_level !== 5'd0) begin failures++; $display("FAIL perr_clear got=err%b lvl%0d exp=err0 lvl0", perr, rx_level); end
        rst = 1'b0; tick();
        wr_n = 1'b0; oe_n = 1'b0; #1;
        checks++; if (ftdi_data !== UNDRIVEN) begin failures++; $display("FAIL perr_wroe_bus got=%h exp=undriven", ftdi_data); end
        tick();
        checks++; if (perr !== 1'b1 || tx_level !== 5'd0) begin failures++; $display("FAIL perr_wroe got=err%b lvl%0d exp=err1 lvl0", perr, tx_level); end
        wr_n = 1'b1; oe_n = 1'b1;
        do_reset();
        host_push(32'h66);
        oe_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; #1;
        checks++; if (ftdi_data !== UNDRIVEN) begin failures++; $display("FAIL perr_rdwr_bus got=%h exp=undriven", ftdi_data); end
        tick();
        checks++; if (perr !== 1'b1 || rx_level !== 5'd1 || tx_level !== 5'd0) begin failures++; $display("FAIL perr_rdwr got=err%b rx%0d tx%0d exp=err1 rx1 tx0", perr, rx_level, tx_level); end
        oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        do_reset();
    endtask

    task automatic test_back_to_back();
        wr_n = 1'b0; tb_drive = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tb_data = 32'hB0 + 32'(k);
            tick();
        end
        checks++; if (tx_level !== 5'd15 || txe_n !== 1'b0 || host_rdata !== 32'hB0) begin failures++; $display("FAIL b2b_fill got=lvl%0d txe%b head%h exp=lvl15 txe0 headb0", tx_level, txe_n, host_rdata); end
        tb_data = 32'hBF; host_rd = 1'b1; tick();
        host_rd = 1'b0; wr_n = 1'b1; tb_drive = 1'b0;
        checks++; if (tx_level !== 5'd15 || host_rdata !== 32'hB1) begin failures++; $display("FAIL b2b_tx_simul got=lvl%0d head%h exp=lvl15 headb1", tx_level, host_rdata); end
        for (int k = 1; k < 16; k++) begin
            checks++; if (host_rdata !== 32'hB0 + 32'(k)) begin failures++; $display("FAIL b2b_tx_word%0d got=%h exp=%h", k, host_rdata, 32'hB0 + 32'(k)); end
            host_rd = 1'b1; tick();
        end
        host_rd = 1'b0;
        for (int k = 0; k < 16; k++) host_push(32'h100 + 32'(k));
        checks++; if (host_full !== 1'b1 || rx_level !== 5'd16) begin failures++; $display("FAIL b2b_rx_full got=f%b lvl%0d exp=f1 lvl16", host_full, rx_level); end
        oe_n = 1'b0; tick();
        rd_n = 1'b0; host_wr = 1'b1; host_wdata = 32'hDEAD; #1;
        checks++; if (ftdi_data !== 32'h100) begin failures++; $display("FAIL b2b_rx_head got=%h exp=100", ftdi_data); end
        tick();
        host_wr = 1'b0;
        checks++; if (rx_level !== 5'd15 || host_full !== 1'b0) begin failures++; $display("FAIL b2b_rx_ignored got=lvl%0d f%b exp=lvl15 f0", rx_level, host_full); end
        for (int k = 1; k < 16; k++) begin
            checks++; if (ftdi_data !== 32'h100 + 32'(k)) begin failures++; $display("FAIL b2b_rx_word%0d got=%h exp=%h", k, ftdi_data, 32'h100 + 32'(k)); end
            tick();
        end
        rd_n = 1'b1;
        checks++; if (rx_level !== 5'd0 || rxf_n !== 1'b1 || ftdi_data !== 32'd0) begin failures++; $display("FAIL b2b_rx_drained got=lvl%0d rxf%b bus%h exp=lvl0 rxf1 bus0", rx_level, rxf_n, ftdi_data); end
        oe_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        rx_hold = 1'b0; tx_hold = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
        host_wdata = '0; tb_drive = 1'b0; tb_data = '0;
        test_reset();
        test_master_read();
        test_master_write();
        test_rx_hold();
        test_protocol_err();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
